// File: rtl/riscv_pkg.sv
// Shared architectural constants for the integer register file and its scoreboard.
package riscv_pkg;
    localparam int XLEN       = 32;
    localparam int NREG       = 32;
    localparam int REG_ADDR_W = 5;
endpackage

// File: rtl/reg_file_if.sv
// Register-file bus: two read ports, write-back port, issue/scoreboard port and debug read.
// Issue handshake: issue_valid is the producer's valid and !stall is ready; the
// scoreboard records issue_rd only on a cycle where issue_valid=1 and stall=0.
interface reg_file_if
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
);
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic                  rd_we;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [XLEN-1:0]       rd_wdata;
    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_rd;
    logic                  rs1_busy;
    logic                  rs2_busy;
    logic                  stall;
    logic [REG_ADDR_W-1:0] dbg_addr;
    logic [XLEN-1:0]       dbg_data;

    modport master (
        output rs1_addr, rs2_addr, rd_we, rd_addr, rd_wdata,
               issue_valid, issue_rd, dbg_addr,
        input  rs1_data, rs2_data, rs1_busy, rs2_busy, stall, dbg_data
    );

    modport slave (
        input  rs1_addr, rs2_addr, rd_we, rd_addr, rd_wdata,
               issue_valid, issue_rd, dbg_addr,
        output rs1_data, rs2_data, rs1_busy, rs2_busy, stall, dbg_data
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: tracks registers with an unwritten producer and raises
// stall on RAW hazards (operand busy) or WAW hazards (re-issue of a busy rd).
module reg_scoreboard
    import riscv_pkg::*;
#(
    parameter int NREG = riscv_pkg::NREG
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic                  rd_we,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  stall
);
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            waw;

    always_comb begin
        rs1_busy = (rs1_addr != '0) && busy_q[rs1_addr] && !(rd_we && rd_addr == rs1_addr);
        rs2_busy = (rs2_addr != '0) && busy_q[rs2_addr] && !(rd_we && rd_addr == rs2_addr);
        waw      = issue_valid && (issue_rd != '0) && busy_q[issue_rd]
                   && !(rd_we && rd_addr == issue_rd);
        stall    = rs1_busy || rs2_busy || waw;
    end

    // Clear before set so a same-cycle issue to the written register wins.
    always_comb begin
        busy_d = busy_q;
        if (rd_we) begin
            busy_d[rd_addr] = 1'b0;
        end
        if (issue_valid && issue_rd != '0 && !stall) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end
endmodule

// File: rtl/reg_file.sv
// Integer register file: storage, combinational reads with write-through bypass,
// hardwired x0, unbypassed debug read, and the hazard scoreboard.
module reg_file
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int NREG = riscv_pkg::NREG
) (
    input  logic      clk,
    input  logic      rst_n,
    reg_file_if.slave rf
);
    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];

    always_comb begin
        regs_d = regs_q;
        if (rf.rd_we && rf.rd_addr != '0) begin
            regs_d[rf.rd_addr] = rf.rd_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Operand reads see the write-back value in the same cycle; debug does not.
    always_comb begin
        if (rf.rs1_addr == '0) begin
            rf.rs1_data = '0;
        end else if (rf.rd_we && rf.rd_addr == rf.rs1_addr) begin
            rf.rs1_data = rf.rd_wdata;
        end else begin
            rf.rs1_data = regs_q[rf.rs1_addr];
        end

        if (rf.rs2_addr == '0) begin
            rf.rs2_data = '0;
        end else if (rf.rd_we && rf.rd_addr == rf.rs2_addr) begin
            rf.rs2_data = rf.rd_wdata;
        end else begin
            rf.rs2_data = regs_q[rf.rs2_addr];
        end

        rf.dbg_data = (rf.dbg_addr == '0) ? '0 : regs_q[rf.dbg_addr];
    end

    reg_scoreboard #(
        .NREG(NREG)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs1_addr   (rf.rs1_addr),
        .rs2_addr   (rf.rs2_addr),
        .rd_we      (rf.rd_we),
        .rd_addr    (rf.rd_addr),
        .issue_valid(rf.issue_valid),
        .issue_rd   (rf.issue_rd),
        .rs1_busy   (rf.rs1_busy),
        .rs2_busy   (rf.rs2_busy),
        .stall      (rf.stall)
    );
endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: directed vector table, reset corner sequences, and random
// traffic checked against an array-based model of the register/busy rules.
module tb_reg_file;
    logic clk;
    logic rst_n;

    int n_vec  = 0;
    int n_miss = 0;

    reg_file_if #(.XLEN(32)) rf ();

    reg_file dut (
        .clk  (clk),
        .rst_n(rst_n),
        .rf   (rf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic        iv;
        logic [4:0]  ir;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  ad;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] ed;
        logic        eb1;
        logic        eb2;
        logic        es;
    } vec_t;

    vec_t vecs[$];

    logic [31:0] m_regs [32];
    bit          m_busy [32];

    function automatic vec_t mk(logic we, logic [4:0] rd, logic [31:0] wd,
                                logic iv, logic [4:0] ir,
                                logic [4:0] a1, logic [4:0] a2, logic [4:0] ad,
                                logic [31:0] e1, logic [31:0] e2, logic [31:0] ed,
                                logic eb1, logic eb2, logic es);
        vec_t v;
        v.we = we; v.rd = rd; v.wd = wd; v.iv = iv; v.ir = ir;
        v.a1 = a1; v.a2 = a2; v.ad = ad;
        v.e1 = e1; v.e2 = e2; v.ed = ed;
        v.eb1 = eb1; v.eb2 = eb2; v.es = es;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] wd,
                         input logic iv, input logic [4:0] ir,
                         input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
        rf.rd_we       = we;
        rf.rd_addr     = rd;
        rf.rd_wdata    = wd;
        rf.issue_valid = iv;
        rf.issue_rd    = ir;
        rf.rs1_addr    = a1;
        rf.rs2_addr    = a2;
        rf.dbg_addr    = ad;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Model of a register-read port as the architecture sees it.
    function automatic logic [31:0] m_read(logic [4:0] a, logic we, logic [4:0] rd, logic [31:0] wd);
        if (a == 0) return 32'd0;
        if (we && rd == a) return wd;
        return m_regs[a];
    endfunction

    function automatic logic m_pending(logic [4:0] a, logic we, logic [4:0] rd);
        return (a != 0) && m_busy[a] && !(we && rd == a);
    endfunction

    initial begin
        logic        we, iv, b1, b2, st;
        logic [4:0]  rd, ir, a1, a2, ad;
        logic [31:0] wd;

        rst_n = 1'b0;
        idle();
        model_reset();
        do_reset();

        // Reset state on a spread of addresses.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'(i * 7 + 1), 5'(i * 5 + 2), 5'(i * 3 + 3));
            #2;
            check("reset_rs1_data", rf.rs1_data, 32'd0);
            check("reset_rs2_data", rf.rs2_data, 32'd0);
            check("reset_dbg_data", rf.dbg_data, 32'd0);
            check("reset_busy", {30'd0, rf.rs1_busy, rf.rs2_busy}, 32'd0);
            check("reset_stall", {31'd0, rf.stall}, 32'd0);
        end

        //          we  rd  wdata         iv  ir  a1  a2  ad  e1            e2     ed            b1 b2 st
        vecs.push_back(mk(1, 3, 32'hDEADBEEF, 0, 0,  3,  0,  3, 32'hDEADBEEF, 0,     0,            0, 0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0,  3,  0,  3, 32'hDEADBEEF, 0,     32'hDEADBEEF, 0, 0, 0));
        vecs.push_back(mk(1, 0, 32'hFFFFFFFF, 0, 0,  0,  0,  0, 0,            0,     0,            0, 0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0,  0,  0,  0, 0,            0,     0,            0, 0, 0));
        vecs.push_back(mk(1, 7, 32'h11,       0, 0,  0,  7,  7, 0,            32'h11, 0,           0, 0, 0));
        vecs.push_back(mk(1, 7, 32'h55,       0, 0,  0,  7,  7, 0,            32'h55, 32'h11,      0, 0, 0));
        vecs.push_back(mk(0, 0, 0,            1, 9,  0,  0,  7, 0,            0,     32'h55,       0, 0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0,  9,  0,  9, 0,            0,     0,            1, 0, 1));
        vecs.push_back(mk(1, 9, 32'h10,       0, 0,  9,  0,  9, 32'h10,       0,     0,            0, 0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0,  9,  0,  9, 32'h10,       0,     32'h10,       0, 0, 0));
        vecs.push_back(mk(1, 4, 32'h22,       1, 4,  0,  0,  4, 0,            0,     0,            0, 0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0,  0,  4,  4, 0,            32'h22, 32'h22,      0, 1, 1));
        vecs.push_back(mk(1, 4, 32'h33,       0, 0,  0,  4,  4, 0,            32'h33, 32'h22,      0, 0, 0));
        vecs.push_back(mk(0, 0, 0,            1, 6,  0,  0,  0, 0,            0,     0,            0, 0, 0));
        vecs.push_back(mk(0, 0, 0,            1, 6,  0,  0,  0, 0,            0,     0,            0, 0, 1));
        vecs.push_back(mk(0, 0, 0,            1, 0,  0,  0,  0, 0,            0,     0,            0, 0, 0));
        vecs.push_back(mk(1, 6, 32'h66,       1, 6,  0,  0,  6, 0,            0,     0,            0, 0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0,  6,  0,  6, 32'h66,       0,     32'h66,       1, 0, 1));
        vecs.push_back(mk(1, 6, 32'h77,       0, 0,  6,  0,  0, 32'h77,       0,     0,            0, 0, 0));
        vecs.push_back(mk(0, 0, 0,            1, 11, 0,  0,  0, 0,            0,     0,            0, 0, 0));
        vecs.push_back(mk(0, 0, 0,            1, 10, 11, 0,  0, 0,            0,     0,            1, 0, 1));
        vecs.push_back(mk(0, 0, 0,            0, 0,  10, 11, 0, 0,            0,     0,            0, 1, 1));
        vecs.push_back(mk(1, 11, 32'h1,       0, 0,  10, 11, 11, 0,           32'h1, 0,            0, 0, 0));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].rd, vecs[i].wd, vecs[i].iv, vecs[i].ir,
                  vecs[i].a1, vecs[i].a2, vecs[i].ad);
            #2;
            check($sformatf("vec%0d_rs1_data", i), rf.rs1_data, vecs[i].e1);
            check($sformatf("vec%0d_rs2_data", i), rf.rs2_data, vecs[i].e2);
            check($sformatf("vec%0d_dbg_data", i), rf.dbg_data, vecs[i].ed);
            check($sformatf("vec%0d_rs1_busy", i), {31'd0, rf.rs1_busy}, {31'd0, vecs[i].eb1});
            check($sformatf("vec%0d_rs2_busy", i), {31'd0, rf.rs2_busy}, {31'd0, vecs[i].eb2});
            check($sformatf("vec%0d_stall", i), {31'd0, rf.stall}, {31'd0, vecs[i].es});
        end

        // Mid-run asynchronous reset clears storage and busy bits without a clock edge.
        @(negedge clk);
        drive(1'b1, 5'd5, 32'h1234, 1'b1, 5'd8, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd8, 5'd0, 5'd5);
        #2;
        check("prereset_dbg_x5", rf.dbg_data, 32'h1234);
        check("prereset_stall", {31'd0, rf.stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_dbg_x5", rf.dbg_data, 32'd0);
        check("async_reset_stall", {31'd0, rf.stall}, 32'd0);
        check("async_reset_rs1_busy", {31'd0, rf.rs1_busy}, 32'd0);
        rf.dbg_addr = 5'd3;
        #1;
        check("async_reset_dbg_x3", rf.dbg_data, 32'd0);

        // Write and issue presented while reset is held are discarded.
        drive(1'b1, 5'd5, 32'hAAAA, 1'b1, 5'd12, 5'd0, 5'd0, 5'd5);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd12, 5'd0, 5'd5);
        #2;
        check("reset_write_discard", rf.dbg_data, 32'd0);
        check("reset_issue_discard", {31'd0, rf.rs1_busy}, 32'd0);
        model_reset();

        // Random traffic over a narrow address range to force collisions.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            we = ($urandom_range(0, 99) < 45);
            rd = 5'($urandom_range(0, 7));
            wd = $urandom;
            iv = ($urandom_range(0, 99) < 40);
            ir = 5'($urandom_range(0, 7));
            a1 = 5'($urandom_range(0, 7));
            a2 = 5'($urandom_range(0, 7));
            ad = 5'($urandom_range(0, 7));
            drive(we, rd, wd, iv, ir, a1, a2, ad);
            b1 = m_pending(a1, we, rd);
            b2 = m_pending(a2, we, rd);
            st = b1 || b2 || (iv && m_pending(ir, we, rd));
            #2;
            check("rand_rs1_data", rf.rs1_data, m_read(a1, we, rd, wd));
            check("rand_rs2_data", rf.rs2_data, m_read(a2, we, rd, wd));
            check("rand_dbg_data", rf.dbg_data, (ad == 0) ? 32'd0 : m_regs[ad]);
            check("rand_rs1_busy", {31'd0, rf.rs1_busy}, {31'd0, b1});
            check("rand_rs2_busy", {31'd0, rf.rs2_busy}, {31'd0, b2});
            check("rand_stall", {31'd0, rf.stall}, {31'd0, st});
            if (we && rd != 0) m_regs[rd] = wd;
            if (we) m_busy[rd] = 1'b0;
            if (iv && ir != 0 && !st) m_busy[ir] = 1'b1;
            if ($urandom_range(0, 99) < 3) do_reset();
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
